moore_seq_detector_param: RTL and testbench
===========================================

Name: moore_seq_detector_param

Overview:
- Parametrised Moore-type serial sequence detector. Successor to the fixed 4-bit overlapping detector.
- Adds:
  - a configurable pattern length;
  - a pattern that can be reloaded at run time;
  - selectable overlapping or non-overlapping detection;
  - input qualification with a valid strobe;
  - a saturating match counter.
- Sits on a serial bit stream and flags recognised frames to downstream control logic.

Parameters:
- SEQ_LEN, 4, pattern length in bits (legal range 2..16).
- DEFAULT_PAT, 4'b1010, pattern in effect after reset (SEQ_LEN bits wide).
- CNT_W, 8, width of match_cnt.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- din  input  1  serial data bit.
- din_valid  input  1  qualifies din; state advances only when high.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  loads pat_in as the active pattern.
- pat_in  input  SEQ_LEN  new pattern; MSB is the first bit expected on din.
- cnt_clr  input  1  clears match_cnt.
- dout  output  1  Moore match flag.
- match_cnt  output  CNT_W  number of matches detected, saturating.

Behaviour:
- Reset (reset==0 at posedge clk):
  - pattern <= DEFAULT_PAT, hist <= 0, fill <= 0, match_cnt <= 0.
  - dout is therefore 0.
  - Reset overrides every other input.
- State registers:
  - hist[SEQ_LEN-1:0]: shift history, newest bit in the LSB.
  - fill: 0..SEQ_LEN, number of valid bits collected, saturating at SEQ_LEN.
  - pattern: active pattern register.
- dout (Moore output) = (fill==SEQ_LEN) && (hist==pattern).
  - Decoded from registered state only; it never depends combinationally on din or din_valid.
  - dout rises in the cycle after the posedge that captures the final pattern bit.
  - dout holds while din_valid is low.
- Valid cycle (din_valid==1, pat_load==0):
  - hist <= {hist[SEQ_LEN-2:0], din}.
  - If dout==1 and overlap_en==0, then fill <= 1: the new bit starts a fresh frame and no bits of the matched frame are reused.
  - Otherwise fill <= min(fill+1, SEQ_LEN).
- Invalid cycle: all state holds.
- overlap_en may change at any time. It is sampled only on the valid cycle that follows a match.
- match_cnt:
  - Increments by 1 on each posedge where the next state is a match.
  - Saturates at 2^CNT_W-1.
  - cnt_clr==1 sets it to 0; this has priority over a same-cycle increment.
- pat_load==1:
  - pattern <= pat_in, hist <= 0, fill <= 0; dout is 0 in the next cycle.
  - din_valid in the same cycle is ignored and that bit is discarded.
  - match_cnt is not affected.
- Reset in the middle of a frame discards the partial frame. Any loaded pattern reverts to DEFAULT_PAT.
- A pattern of all zeros or all ones is legal. In overlapping mode it produces a match on every valid bit once fill saturates.

Test Plan:
- Overlap, default pattern 1010: din_valid continuous, stream 101010101010.
  - dout pulses after bits 4, 6, 8, 10 and 12, each lasting one cycle.
  - match_cnt = 5.
- Non-overlap: same stream with overlap_en = 0.
  - dout after bits 4, 8 and 12 only; match_cnt = 3.
- Valid gaps: stream 1,0,1,0 with din_valid low for 3 cycles between each bit.
  - Single match after the 4th valid bit.
  - dout stays high through the following idle cycles until the next valid bit (0), which clears it.
- Pattern load: pat_in = 1101, pat_load pulsed with din_valid = 1 in the same cycle, then stream 1101101.
  - Overlap: matches after bits 4 and 7, match_cnt += 2.
  - Non-overlap: single match after bit 4, match_cnt += 1.
  - The bit presented with pat_load is not counted.
- Reset mid-frame: load 1101, feed 1,1,0, drive reset low for one cycle, then feed 1,0,1,0.
  - No match on the stale 1,1,0 + 1.
  - Match after the 4th bit under DEFAULT_PAT; match_cnt = 1.
- Counter: build with CNT_W = 2, overlap stream 101010101010 (5 matches).
  - match_cnt saturates at 3.
  - Asserting cnt_clr on a match cycle gives match_cnt = 0.

Source files
------------

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector.
// Shifts qualified bits into a history register and flags a frame when the
// history matches the active pattern. Matching can overlap or not, the
// pattern can be reloaded at run time, and a saturating counter tallies hits.
module moore_seq_detector_param #(
  parameter int unsigned          SEQ_LEN     = 4,        // 2..16
  parameter logic [SEQ_LEN-1:0]   DEFAULT_PAT = 4'b1010,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,       // synchronous, active low
  input  logic               din,
  input  logic               din_valid,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [SEQ_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned           FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0]     FILL_ONE  = FILL_W'(1);

  logic [SEQ_LEN-1:0] pattern_q, pattern_d;
  logic [SEQ_LEN-1:0] hist_q,    hist_d;
  logic [FILL_W-1:0]  fill_q,    fill_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               advance;
  logic               match_next;

  // Moore output: decoded from registered state only, never from din.
  assign dout      = (fill_q == FILL_FULL) && (hist_q == pattern_q);
  assign match_cnt = cnt_q;

  // A bit is consumed only when valid and not shadowed by a pattern load.
  assign advance = din_valid && !pat_load;

  // Next-state for pattern, history and fill level.
  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      hist_d = {hist_q[SEQ_LEN-2:0], din};
      if (dout && !overlap_en) begin
        // Non-overlapping: the matched frame is spent, this bit opens a new one.
        fill_d = FILL_ONE;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // Match counter: counts valid bits that complete a frame; idle cycles that
  // merely hold a match are not recounted. Clear wins over increment.
  always_comb begin
    match_next = (fill_d == FILL_FULL) && (hist_d == pattern_d);
    cnt_d      = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (advance && match_next && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      pattern_q <= DEFAULT_PAT;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Directed bench for moore_seq_detector_param: one task per scenario, with
// hand-computed expected dout/match_cnt. A second instance with a 2-bit
// counter shares the stimulus and is checked for saturation.
module tb_moore_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       overlap_en;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;
  logic       dout;
  logic [7:0] match_cnt;
  logic       dout2;
  logic [1:0] match_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  moore_seq_detector_param #(.SEQ_LEN(4), .DEFAULT_PAT(4'b1010), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .dout(dout), .match_cnt(match_cnt)
  );

  moore_seq_detector_param #(.SEQ_LEN(4), .DEFAULT_PAT(4'b1010), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .dout(dout2), .match_cnt(match_cnt2)
  );

  // One clock: inputs are applied, the edge happens, outputs are sampled 1ns later.
  task automatic step(input logic b, input logic v);
    din       = b;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b want=0", dout); end
    total++;
    if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    total++;
    if (match_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_cnt2 got=%0d want=0", match_cnt2); end
  endtask

  task automatic test_overlap();
    logic [11:0] s = 12'b1010_1010_1010;
    logic [11:0] e = 12'b0001_0101_0101;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 11; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (dout !== e[i]) begin
        bad++; $display("FAIL overlap_dout bit=%0d got=%b want=%b", 12 - i, dout, e[i]);
      end
    end
    total++;
    if (match_cnt !== 8'd5) begin bad++; $display("FAIL overlap_cnt got=%0d want=5", match_cnt); end
  endtask

  task automatic test_non_overlap();
    logic [11:0] s = 12'b1010_1010_1010;
    logic [11:0] e = 12'b0001_0001_0001;
    do_reset();
    overlap_en = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (dout !== e[i]) begin
        bad++; $display("FAIL nonovl_dout bit=%0d got=%b want=%b", 12 - i, dout, e[i]);
      end
    end
    total++;
    if (match_cnt !== 8'd3) begin bad++; $display("FAIL nonovl_cnt got=%0d want=3", match_cnt); end
    overlap_en = 1'b1;
  endtask

  task automatic test_valid_gaps();
    logic [3:0] s = 4'b1010;
    logic [3:0] e = 4'b0001;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step(s[i], 1'b1);
      for (int g = 0; g < 3; g++) begin
        step(1'b1, 1'b0);   // idle, din toggled to show it is ignored
        total++;
        if (dout !== e[i]) begin
          bad++; $display("FAIL gap_dout bit=%0d idle=%0d got=%b want=%b", 4 - i, g, dout, e[i]);
        end
      end
    end
    total++;
    if (match_cnt !== 8'd1) begin bad++; $display("FAIL gap_cnt got=%0d want=1", match_cnt); end
    step(1'b0, 1'b1);
    total++;
    if (dout !== 1'b0) begin bad++; $display("FAIL gap_clear got=%b want=0", dout); end
  endtask

  task automatic test_pat_load();
    logic [6:0] s  = 7'b1101101;
    logic [6:0] eo = 7'b0001001;
    logic [6:0] en = 7'b0001000;
    do_reset();
    overlap_en = 1'b1;
    // Load with a valid bit presented in the same cycle; that bit is dropped.
    pat_in = 4'b1101; pat_load = 1'b1;
    step(1'b1, 1'b1);
    pat_load = 1'b0;
    total++;
    if (dout !== 1'b0) begin bad++; $display("FAIL load_dout got=%b want=0", dout); end
    for (int i = 6; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (dout !== eo[i]) begin
        bad++; $display("FAIL load_ovl_dout bit=%0d got=%b want=%b", 7 - i, dout, eo[i]);
      end
    end
    total++;
    if (match_cnt !== 8'd2) begin bad++; $display("FAIL load_ovl_cnt got=%0d want=2", match_cnt); end
    // Reload in non-overlap mode; the counter must survive the load.
    overlap_en = 1'b0; pat_load = 1'b1;
    step(1'b1, 1'b1);
    pat_load = 1'b0;
    total++;
    if (match_cnt !== 8'd2) begin bad++; $display("FAIL load_keeps_cnt got=%0d want=2", match_cnt); end
    for (int i = 6; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (dout !== en[i]) begin
        bad++; $display("FAIL load_nonovl_dout bit=%0d got=%b want=%b", 7 - i, dout, en[i]);
      end
    end
    total++;
    if (match_cnt !== 8'd3) begin bad++; $display("FAIL load_nonovl_cnt got=%0d want=3", match_cnt); end
    overlap_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] p = 3'b110;
    logic [3:0] s = 4'b1010;
    logic [3:0] e = 4'b0001;
    do_reset();
    overlap_en = 1'b1;
    pat_in = 4'b1101; pat_load = 1'b1;
    step(1'b0, 1'b0);
    pat_load = 1'b0;
    for (int i = 2; i >= 0; i--) step(p[i], 1'b1);
    // Reset with a valid bit present: reset must win.
    reset = 1'b0;
    step(1'b1, 1'b1);
    reset = 1'b1;
    total++;
    if (dout !== 1'b0 || match_cnt !== 8'd0) begin
      bad++; $display("FAIL midrst_state got=%b/%0d want=0/0", dout, match_cnt);
    end
    for (int i = 3; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++;
      if (dout !== e[i]) begin
        bad++; $display("FAIL midrst_dout bit=%0d got=%b want=%b", 4 - i, dout, e[i]);
      end
    end
    total++;
    if (match_cnt !== 8'd1) begin bad++; $display("FAIL midrst_cnt got=%0d want=1", match_cnt); end
  endtask

  task automatic test_counter();
    logic [11:0] s = 12'b1010_1010_1010;
    do_reset();
    overlap_en = 1'b1;
    for (int i = 11; i >= 0; i--) step(s[i], 1'b1);
    total++;
    if (match_cnt2 !== 2'd3) begin bad++; $display("FAIL cnt_sat got=%0d want=3", match_cnt2); end
    total++;
    if (match_cnt !== 8'd5) begin bad++; $display("FAIL cnt_wide got=%0d want=5", match_cnt); end
    // Two more bits (1,0) produce a match on the second; clear on that cycle.
    step(1'b1, 1'b1);
    cnt_clr = 1'b1;
    step(1'b0, 1'b1);
    cnt_clr = 1'b0;
    total++;
    if (dout !== 1'b1) begin bad++; $display("FAIL clr_dout got=%b want=1", dout); end
    total++;
    if (match_cnt2 !== 2'd0 || match_cnt !== 8'd0) begin
      bad++; $display("FAIL clr_priority got=%0d/%0d want=0/0", match_cnt2, match_cnt);
    end
  endtask

  initial begin
    reset      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    overlap_en = 1'b1;
    pat_load   = 1'b0;
    pat_in     = 4'b0000;
    cnt_clr    = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_pat_load();
    test_reset_mid_frame();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
